mux2_arbiter: RTL and testbench
===============================

# mux2_arbiter

Two-requester round-robin arbiter that shares one `Mux2` datapath between two valid/ready source channels and delivers the winner's data through a one-entry registered output stage. It generates the `Mux2` select internally and sustains one transfer per cycle. It sits between two producers and a single downstream consumer wherever a 2:1 shared resource must be time-multiplexed fairly.

## Interface
Parameters:
- `WIDTH`, 8: data width of each channel and of the internal `Mux2` instance.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in1_valid`  in  1  channel 1 has data.
- `in1_ready`  out  1  channel 1 beat accepted this cycle when high with `in1_valid`.
- `in1_data`  in  WIDTH  channel 1 payload.
- `in1_last`  in  1  final beat of a channel 1 packet; used only with `MUX2_ARB_LOCK_EN`.
- `in2_valid`, `in2_ready`, `in2_data`, `in2_last`: same as channel 1, for channel 2.
- `out_valid`  out  1  output register holds data.
- `out_ready`  in  1  downstream accepts the output.
- `out_data`  out  WIDTH  registered payload.
- `sel`  out  1  current grant / `Mux2` select: 0 = in1, 1 = in2.

## Operation
- Internal `Mux2#(WIDTH)`: `in1` = `in1_data`, `in2` = `in2_data`, `sel` = grant; its output feeds the output register.
- Pointer `last` records the most recent winner. Reset value is 1 (in2), so in1 wins the first contested cycle.
- `take` = `!out_valid || out_ready`, meaning the register is empty or draining this cycle.
- Grant (combinational) when unlocked:
  - only one channel valid: that channel wins;
  - both valid: the channel not equal to `last` wins;
  - neither valid: grant holds its previous value, so `sel` is stable.
- `inX_ready` = (grant == X) && `take`. The losing channel's ready is 0.
- On an accept (`inX_valid && inX_ready`):
  - `out_data` ← mux output;
  - `out_valid` ← 1;
  - `last` ← X.
- When `out_valid && out_ready` with no accept, `out_valid` ← 0.
- Accept and drain in the same cycle: register reloads and `out_valid` stays 1, giving full throughput.
- States:
  - IDLE: unlocked.
  - LOCK1 / LOCK2: grant forced to that channel. These states exist only with the macro.
- Transitions:
  - IDLE → LOCKX on an accept from X with `inX_last` = 0.
  - LOCKX → IDLE on an accept from X with `inX_last` = 1.
  - Otherwise the state holds.
  - While locked, the other channel's ready is 0 even if the locked channel is idle.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `sel` = 0;
  - `in1_ready` = 1 and `in2_ready` = 0 (grant 0, `take` = 1);
  - `last` = 1, state IDLE.
- Latency: accept at edge N gives `out_valid` = 1 with the data at edge N+1.
- Throughput: one beat per cycle while `out_ready` = 1.
- Stall: with `out_valid && !out_ready`, `out_data` and `out_valid` hold stable and both inputs' ready are 0.
- Fairness: with both channels continuously valid and `out_ready` = 1, grants alternate every beat (unlocked) or every packet (locked).
- Readies depend combinationally on `out_ready` and the valids. Data is not combinationally dependent on any input.
- Reset asserted mid-packet: lock released, pending output discarded, all values return to the reset values above.

## Configuration
- `MUX2_ARB_LOCK_EN` defined: packet lock is active. The LOCK1/LOCK2 states are compiled in, and `in1_last` / `in2_last` are honoured.
- Not defined: arbitration is re-evaluated every beat, `inX_last` is ignored (unconnected internally), and no lock state exists.

## Test plan
- Reset: drive `rst_n` = 0 mid-traffic → `out_valid` = 0, `out_data` = 0, `sel` = 0, `in1_ready` = 1 after `out_ready` = 1, and in1 wins the first contest.
- Single requester: only in2 valid with data 0x11, 0x22, 0x33, `out_ready` = 1 → `out_data` shows 0x11, 0x22, 0x33 on consecutive cycles, one cycle after each accept; `sel` = 1.
- Contention, unlocked: in1 presents 0xA0..., in2 presents 0xB0..., both always valid → output A0, B0, A1, B1, ... with no bubbles.
- Backpressure: hold `out_ready` = 0 for 3 cycles with `out_valid` = 1 and value 0x5A → `out_data` stays 0x5A and both readies are 0; releasing `out_ready` accepts the next beat in the same cycle.
- Lock (macro on): in1 sends a 3-beat packet (last on beat 3) while in2 stays valid → three in1 beats, then in2; with in1 idle mid-packet, in2 stays blocked.
- Lock disabled (macro off): same stimulus → beats interleave in1, in2, in1, ...; `last` inputs have no effect.

Source files
------------

// File: rtl/mux2_arbiter.sv
// Two-channel round-robin arbiter sharing one Mux2 datapath, with a one-entry registered output.
// Define MUX2_ARB_LOCK_EN to hold the grant for a whole packet (until inX_last is accepted).

module Mux2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);
  assign out = sel ? in2 : in1;
endmodule

module mux2_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  input  logic             in2_valid,
  output logic             in2_ready,
  input  logic [WIDTH-1:0] in2_data,
  input  logic             in2_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             sel
);

  logic             grant_d, grant_q;
  logic             last_d, last_q;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] out_data_d, out_data_q;
  logic [WIDTH-1:0] mux_out;
  logic             take, acc1, acc2;

`ifdef MUX2_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, LOCK1, LOCK2} state_e;
  state_e state_d, state_q;
`else
  logic unused_last;
  assign unused_last = in1_last ^ in2_last;
`endif

  Mux2 #(.WIDTH(WIDTH)) u_mux2 (
    .in1 (in1_data),
    .in2 (in2_data),
    .sel (grant_d),
    .out (mux_out)
  );

  // With no requester the previous grant is kept so sel does not toggle idly.
  always_comb begin
    grant_d = grant_q;
    if (in1_valid && !in2_valid)      grant_d = 1'b0;
    else if (!in1_valid && in2_valid) grant_d = 1'b1;
    else if (in1_valid && in2_valid)  grant_d = ~last_q;
`ifdef MUX2_ARB_LOCK_EN
    if (state_q == LOCK1)      grant_d = 1'b0;
    else if (state_q == LOCK2) grant_d = 1'b1;
`endif
  end

  assign take      = !out_valid_q || out_ready;
  assign in1_ready = !grant_d && take;
  assign in2_ready =  grant_d && take;
  assign acc1      = in1_valid && in1_ready;
  assign acc2      = in2_valid && in2_ready;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (acc1 || acc2) begin
      out_data_d  = mux_out;
      out_valid_d = 1'b1;
      last_d      = acc2;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef MUX2_ARB_LOCK_EN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (acc1 && !in1_last)      state_d = LOCK1;
        else if (acc2 && !in2_last) state_d = LOCK2;
      end
      LOCK1:   if (acc1 && in1_last) state_d = IDLE;
      LOCK2:   if (acc2 && in2_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      grant_q     <= grant_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = grant_d;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed-vector bench for mux2_arbiter; expectations are hand-computed per cycle.
// The packet-lock section follows MUX2_ARB_LOCK_EN of the build.

module tb_mux2_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in1_valid, in1_ready, in1_last;
  logic [7:0] in1_data;
  logic       in2_valid, in2_ready, in2_last;
  logic [7:0] in2_data;
  logic       out_valid, out_ready, sel;
  logic [7:0] out_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux2_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in2_valid (in2_valid),
    .in2_ready (in2_ready),
    .in2_data  (in2_data),
    .in2_last  (in2_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check at the falling edge, then step past the rising edge.
  task automatic vec(input string tag,
                     input logic i1v, input logic [7:0] i1d, input logic i1l,
                     input logic i2v, input logic [7:0] i2d, input logic i2l,
                     input logic ordy,
                     input logic er1, input logic er2, input logic esel,
                     input logic eov, input logic [7:0] eod);
    in1_valid = i1v; in1_data = i1d; in1_last = i1l;
    in2_valid = i2v; in2_data = i2d; in2_last = i2l;
    out_ready = ordy;
    @(negedge clk);
    chk({tag, ".in1_ready"}, 32'(in1_ready), 32'(er1));
    chk({tag, ".in2_ready"}, 32'(in2_ready), 32'(er2));
    chk({tag, ".sel"},       32'(sel),       32'(esel));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
    chk({tag, ".out_data"},  32'(out_data),  32'(eod));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in1_valid = 0; in1_data = 0; in1_last = 0;
    in2_valid = 0; in2_data = 0; in2_last = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    vec("rst", 0,8'h00,0, 0,8'h00,0, 1,  1,0,0, 0,8'h00);
    rst_n = 1'b1;

    // single requester on channel 2
    vec("s1",  0,8'h00,0, 1,8'h11,1, 1,  0,1,1, 0,8'h00);
    vec("s2",  0,8'h00,0, 1,8'h22,1, 1,  0,1,1, 1,8'h11);
    vec("s3",  0,8'h00,0, 1,8'h33,1, 1,  0,1,1, 1,8'h22);
    vec("s4",  0,8'h00,0, 0,8'h00,0, 1,  0,1,1, 1,8'h33);
    vec("s5",  0,8'h00,0, 0,8'h00,0, 1,  0,1,1, 0,8'h33);

    // both valid, unlocked: alternate with no bubbles
    vec("c0",  1,8'hA0,1, 1,8'hB0,1, 1,  1,0,0, 0,8'h33);
    vec("c1",  1,8'hA1,1, 1,8'hB0,1, 1,  0,1,1, 1,8'hA0);
    vec("c2",  1,8'hA1,1, 1,8'hB1,1, 1,  1,0,0, 1,8'hB0);
    vec("c3",  1,8'hA2,1, 1,8'hB1,1, 1,  0,1,1, 1,8'hA1);
    vec("c4",  1,8'hA2,1, 1,8'hB2,1, 1,  1,0,0, 1,8'hB1);
    vec("c5",  1,8'hA3,1, 1,8'hB2,1, 1,  0,1,1, 1,8'hA2);

    // backpressure: 0x5A held three cycles, then reload on release
    vec("b0",  1,8'h5A,1, 0,8'h00,1, 1,  1,0,0, 1,8'hB2);
    vec("b1",  1,8'h5B,1, 1,8'hC0,1, 0,  0,0,1, 1,8'h5A);
    vec("b2",  1,8'h5B,1, 1,8'hC0,1, 0,  0,0,1, 1,8'h5A);
    vec("b3",  1,8'h5B,1, 1,8'hC0,1, 0,  0,0,1, 1,8'h5A);
    vec("b4",  1,8'h5B,1, 1,8'hC0,1, 1,  0,1,1, 1,8'h5A);
    vec("b5",  1,8'h5B,1, 0,8'h00,1, 1,  1,0,0, 1,8'hC0);
    vec("b6",  0,8'h00,0, 0,8'h00,0, 1,  1,0,0, 1,8'h5B);

    // reset with a pending output, then in1 wins the first contest
    vec("r0",  1,8'h77,1, 1,8'h88,1, 0,  0,1,1, 0,8'h5B);
    rst_n = 1'b0;
    vec("r1",  1,8'h77,1, 1,8'h88,1, 1,  1,0,0, 0,8'h00);
    rst_n = 1'b1;
    vec("r2",  1,8'h77,1, 1,8'h88,1, 1,  1,0,0, 0,8'h00);
    vec("r3",  0,8'h00,0, 0,8'h00,0, 1,  1,0,0, 1,8'h77);
    vec("r4",  0,8'h00,0, 0,8'h00,0, 1,  1,0,0, 0,8'h77);

    rst_n = 1'b0;
    vec("r5",  0,8'h00,0, 0,8'h00,0, 1,  1,0,0, 0,8'h00);
    rst_n = 1'b1;

`ifdef MUX2_ARB_LOCK_EN
    // in1 3-beat packet with an idle gap; in2 blocked until last beat
    vec("l0",  1,8'hD1,0, 1,8'hE1,1, 1,  1,0,0, 0,8'h00);
    vec("l1",  0,8'h00,0, 1,8'hE1,1, 1,  1,0,0, 1,8'hD1);
    vec("l2",  1,8'hD2,0, 1,8'hE1,1, 1,  1,0,0, 0,8'hD1);
    vec("l3",  1,8'hD3,1, 1,8'hE1,1, 1,  1,0,0, 1,8'hD2);
    vec("l4",  0,8'h00,0, 1,8'hE1,1, 1,  0,1,1, 1,8'hD3);
    vec("l5",  0,8'h00,0, 1,8'hE2,1, 1,  0,1,1, 1,8'hE1);
    vec("l6",  0,8'h00,0, 0,8'h00,0, 1,  0,1,1, 1,8'hE2);
`else
    // same packet stimulus, last ignored: beats interleave
    vec("u0",  1,8'hD1,0, 1,8'hE1,1, 1,  1,0,0, 0,8'h00);
    vec("u1",  0,8'h00,0, 1,8'hE1,1, 1,  0,1,1, 1,8'hD1);
    vec("u2",  1,8'hD2,0, 1,8'hE2,1, 1,  1,0,0, 1,8'hE1);
    vec("u3",  1,8'hD3,1, 1,8'hE2,1, 1,  0,1,1, 1,8'hD2);
    vec("u4",  1,8'hD3,1, 1,8'hE3,1, 1,  1,0,0, 1,8'hE2);
    vec("u5",  0,8'h00,0, 1,8'hE3,1, 1,  0,1,1, 1,8'hD3);
    vec("u6",  0,8'h00,0, 0,8'h00,0, 1,  0,1,1, 1,8'hE3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
